knn_ctrl: RTL and testbench

- Sequencer for the KNN distance datapath (accumulating squared-difference core).
- For one latched test point it does four things:
  - fetches N training points, each (x, y, label), over a simple req/ack memory port;
  - drives the core's clear, enable and accumulate controls;
  - captures each distance;
  - keeps a sorted K-nearest list readable by software.
- Sits between the KNN register file/CPU slave and the distance core.

---
 rtl/knn_ctrl_pkg.sv | 26 ++
 rtl/knn_kbest.sv | 101 ++++++++++
 rtl/knn_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_knn_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_ctrl_pkg.sv
// Shared types and defaults for the KNN search sequencer.
// Optional majority vote is enabled by defining KNN_CTRL_VOTE_EN.
package knn_ctrl_pkg;

    localparam int DATA_W_D  = 32;
    localparam int DIST_W_D  = 32;
    localparam int IDX_W_D   = 10;
    localparam int LABEL_W_D = 8;
    localparam int K_D       = 4;
    localparam int DP_LAT_D  = 1;

    localparam logic [DIST_W_D-1:0] DIST_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_CLR,
        S_ACC0,
        S_ACC1,
        S_WAIT,
        S_INSERT,
        S_VOTE,
        S_DONE
    } state_t;

endpackage

// File: rtl/knn_kbest.sv
// K-entry ascending nearest-neighbour list with single-cycle sorted insert.
// Exposes all labels for the vote when KNN_CTRL_VOTE_EN is defined.
module knn_kbest
    import knn_ctrl_pkg::*;
#(
    parameter int K       = K_D,
    parameter int DIST_W  = DIST_W_D,
    parameter int IDX_W   = IDX_W_D,
    parameter int LABEL_W = LABEL_W_D,
    localparam int SW     = $clog2(K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_ins,
    input  logic [DIST_W-1:0]  i_dist,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic [LABEL_W-1:0] i_label,
    input  logic [SW-1:0]      i_slot,
    output logic               o_valid,
    output logic [DIST_W-1:0]  o_dist,
    output logic [IDX_W-1:0]   o_idx,
    output logic [LABEL_W-1:0] o_label
`ifdef KNN_CTRL_VOTE_EN
    ,
    output logic [K-1:0]              o_vld_all,
    output logic [K-1:0][LABEL_W-1:0] o_lbl_all
`endif
);

    logic [K-1:0]              r_vld;
    logic [K-1:0][DIST_W-1:0]  r_dist;
    logic [K-1:0][IDX_W-1:0]   r_idx;
    logic [K-1:0][LABEL_W-1:0] r_lbl;

    logic [K-1:0]       w_gt;
    logic [K-1:0]       w_here;
    logic [K-1:0]       w_shift;
    logic               w_pv [K];
    logic [DIST_W-1:0]  w_pd [K];
    logic [IDX_W-1:0]   w_pi [K];
    logic [LABEL_W-1:0] w_pl [K];

    // Invalid slots act as +infinity; strict compare keeps ties in arrival order
    always_comb begin
        w_gt = '0;
        for (int i = 0; i < K; i++) begin
            w_gt[i] = !r_vld[i] || (r_dist[i] > i_dist);
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_slot
        if (g == 0) begin : g_head
            assign w_here[g]  = w_gt[g];
            assign w_shift[g] = 1'b0;
            assign w_pv[g]    = 1'b0;
            assign w_pd[g]    = '0;
            assign w_pi[g]    = '0;
            assign w_pl[g]    = '0;
        end else begin : g_tail
            assign w_here[g]  = w_gt[g] && !w_gt[g-1];
            assign w_shift[g] = w_gt[g-1];
            assign w_pv[g]    = r_vld[g-1];
            assign w_pd[g]    = r_dist[g-1];
            assign w_pi[g]    = r_idx[g-1];
            assign w_pl[g]    = r_lbl[g-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < K; i++) begin
            if (rst || i_clr) begin
                r_vld[i]  <= 1'b0;
                r_dist[i] <= DIST_W'(DIST_MAX);
                r_idx[i]  <= '0;
                r_lbl[i]  <= '0;
            end else if (i_ins && w_here[i]) begin
                r_vld[i]  <= 1'b1;
                r_dist[i] <= i_dist;
                r_idx[i]  <= i_idx;
                r_lbl[i]  <= i_label;
            end else if (i_ins && w_shift[i]) begin
                r_vld[i]  <= w_pv[i];
                r_dist[i] <= w_pd[i];
                r_idx[i]  <= w_pi[i];
                r_lbl[i]  <= w_pl[i];
            end
        end
    end

    assign o_valid = r_vld[i_slot];
    assign o_dist  = r_dist[i_slot];
    assign o_idx   = r_idx[i_slot];
    assign o_label = r_lbl[i_slot];

`ifdef KNN_CTRL_VOTE_EN
    assign o_vld_all = r_vld;
    assign o_lbl_all = r_lbl;
`endif

endmodule

// File: rtl/knn_ctrl.sv
// KNN search sequencer: fetches points, drives the distance core, keeps K best.
// Define KNN_CTRL_VOTE_EN to add the post-search label vote (vote_label/vote_valid).
module knn_ctrl
    import knn_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_D,
    parameter int DIST_W  = DIST_W_D,
    parameter int IDX_W   = IDX_W_D,
    parameter int LABEL_W = LABEL_W_D,
    parameter int K       = K_D,
    parameter int DP_LAT  = DP_LAT_D,
    localparam int SW     = $clog2(K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W-1:0]   n_points,
    input  logic [DATA_W-1:0]  test_x,
    input  logic [DATA_W-1:0]  test_y,
    output logic               busy,
    output logic               done,
    output logic               mem_req,
    output logic [IDX_W-1:0]   mem_addr,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_x,
    input  logic [DATA_W-1:0]  mem_y,
    input  logic [LABEL_W-1:0] mem_label,
    output logic               dp_rst_acc,
    output logic               dp_en,
    output logic [DATA_W-1:0]  dp_a,
    output logic [DATA_W-1:0]  dp_b,
    input  logic [DIST_W-1:0]  dp_dist,
    input  logic [SW-1:0]      rd_slot,
    output logic               rd_valid,
    output logic [DIST_W-1:0]  rd_dist,
    output logic [IDX_W-1:0]   rd_index,
    output logic [LABEL_W-1:0] rd_label
`ifdef KNN_CTRL_VOTE_EN
    ,
    output logic [LABEL_W-1:0] vote_label,
    output logic               vote_valid
`endif
);

    localparam int WW = $clog2(DP_LAT + 1);

    state_t             r_state, w_next;
    logic [IDX_W-1:0]   r_cnt, r_n;
    logic [DATA_W-1:0]  r_tx, r_ty, r_x, r_y;
    logic [LABEL_W-1:0] r_lbl;
    logic [DIST_W-1:0]  r_dist;
    logic [WW-1:0]      r_wcnt;
    logic               r_busy, r_done;
    logic               w_accept, w_clr, w_ins, w_last, w_wlast;

    assign w_last  = (r_cnt == r_n - IDX_W'(1));
    assign w_wlast = (r_wcnt == WW'(DP_LAT - 1));

`ifdef KNN_CTRL_VOTE_EN
    localparam int CW = $clog2(K + 1);

    logic [SW-1:0]              r_vidx;
    logic [CW-1:0]              r_vbest, w_vcnt;
    logic [LABEL_W-1:0]         r_vlbl;
    logic                       r_vvalid;
    logic [K-1:0]               w_vld_all;
    logic [K-1:0][LABEL_W-1:0]  w_lbl_all;
    logic                       w_vdone;

    assign w_vdone = (r_vidx == SW'(K - 1));

    always_comb begin
        w_vcnt = '0;
        for (int j = 0; j < K; j++) begin
            if (w_vld_all[j] && w_lbl_all[j] == w_lbl_all[r_vidx]) begin
                w_vcnt = w_vcnt + CW'(1);
            end
        end
    end

    // Strict compare while scanning from slot 0 hands ties to the nearest slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vidx   <= '0;
            r_vbest  <= '0;
            r_vlbl   <= '0;
            r_vvalid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_vidx   <= '0;
                r_vbest  <= '0;
                r_vlbl   <= '0;
                r_vvalid <= 1'b0;
            end
            if (r_state == S_VOTE) begin
                r_vidx <= r_vidx + SW'(1);
                if (w_vld_all[r_vidx] && w_vcnt > r_vbest) begin
                    r_vbest <= w_vcnt;
                    r_vlbl  <= w_lbl_all[r_vidx];
                end
            end
            if (r_state == S_DONE) begin
                r_vvalid <= w_vld_all[0];
            end
        end
    end

    assign vote_label = r_vlbl;
    assign vote_valid = r_vvalid;
`endif

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_clr    = 1'b0;
        w_ins    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_clr    = 1'b1;
                    w_next   = (n_points == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:  if (mem_ack) w_next = S_CLR;
            S_CLR:    w_next = S_ACC0;
            S_ACC0:   w_next = S_ACC1;
            S_ACC1:   w_next = S_WAIT;
            S_WAIT:   if (w_wlast) w_next = S_INSERT;
            S_INSERT: begin
                w_ins = 1'b1;
`ifdef KNN_CTRL_VOTE_EN
                w_next = w_last ? S_VOTE : S_FETCH;
`else
                w_next = w_last ? S_DONE : S_FETCH;
`endif
            end
`ifdef KNN_CTRL_VOTE_EN
            S_VOTE:   if (w_vdone) w_next = S_DONE;
`endif
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
            r_tx    <= '0;
            r_ty    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_lbl   <= '0;
            r_dist  <= '0;
            r_wcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_DONE);
            if (w_accept) begin
                r_busy <= 1'b1;
                r_n    <= n_points;
                r_tx   <= test_x;
                r_ty   <= test_y;
                r_cnt  <= '0;
            end else if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end
            if (r_state == S_FETCH && mem_ack) begin
                r_x   <= mem_x;
                r_y   <= mem_y;
                r_lbl <= mem_label;
            end
            if (r_state == S_ACC1) begin
                r_wcnt <= '0;
            end
            if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt + WW'(1);
                if (w_wlast) r_dist <= dp_dist;
            end
            if (r_state == S_INSERT && !w_last) begin
                r_cnt <= r_cnt + IDX_W'(1);
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign mem_req    = (r_state == S_FETCH);
    assign mem_addr   = mem_req ? r_cnt : '0;
    assign dp_rst_acc = (r_state == S_CLR);
    assign dp_en      = (r_state == S_ACC0) || (r_state == S_ACC1);
    assign dp_a       = (r_state == S_ACC0) ? r_tx :
                        (r_state == S_ACC1) ? r_ty : '0;
    assign dp_b       = (r_state == S_ACC0) ? r_x :
                        (r_state == S_ACC1) ? r_y : '0;

    knn_kbest #(
        .K       (K),
        .DIST_W  (DIST_W),
        .IDX_W   (IDX_W),
        .LABEL_W (LABEL_W)
    ) u_kbest (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_ins     (w_ins),
        .i_dist    (r_dist),
        .i_idx     (r_cnt),
        .i_label   (r_lbl),
        .i_slot    (rd_slot),
        .o_valid   (rd_valid),
        .o_dist    (rd_dist),
        .o_idx     (rd_index),
        .o_label   (rd_label)
`ifdef KNN_CTRL_VOTE_EN
        ,
        .o_vld_all (w_vld_all),
        .o_lbl_all (w_lbl_all)
`endif
    );

endmodule

// File: tb/tb_knn_ctrl.sv
// Randomised self-checking bench for knn_ctrl against a top-K reference.
// Vote outputs are checked when KNN_CTRL_VOTE_EN is defined.
module tb_knn_ctrl;

    localparam int DATA_W  = 32;
    localparam int DIST_W  = 32;
    localparam int IDX_W   = 10;
    localparam int LABEL_W = 8;
    localparam int K       = 4;
    localparam int DP_LAT  = 1;
    localparam int SW      = $clog2(K);

    logic               clk = 1'b0;
    logic               rst, start;
    logic [IDX_W-1:0]   n_points;
    logic [DATA_W-1:0]  test_x, test_y;
    logic               busy, done, mem_req, mem_ack;
    logic [IDX_W-1:0]   mem_addr;
    logic [DATA_W-1:0]  mem_x, mem_y;
    logic [LABEL_W-1:0] mem_label;
    logic               dp_rst_acc, dp_en;
    logic [DATA_W-1:0]  dp_a, dp_b;
    logic [DIST_W-1:0]  dp_dist;
    logic [SW-1:0]      rd_slot;
    logic               rd_valid;
    logic [DIST_W-1:0]  rd_dist;
    logic [IDX_W-1:0]   rd_index;
    logic [LABEL_W-1:0] rd_label;
`ifdef KNN_CTRL_VOTE_EN
    logic [LABEL_W-1:0] vote_label;
    logic               vote_valid;
`endif

    always #5 clk = ~clk;

    knn_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_points   (n_points),
        .test_x     (test_x),
        .test_y     (test_y),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_x      (mem_x),
        .mem_y      (mem_y),
        .mem_label  (mem_label),
        .dp_rst_acc (dp_rst_acc),
        .dp_en      (dp_en),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_dist    (dp_dist),
        .rd_slot    (rd_slot),
        .rd_valid   (rd_valid),
        .rd_dist    (rd_dist),
        .rd_index   (rd_index),
        .rd_label   (rd_label)
`ifdef KNN_CTRL_VOTE_EN
        ,
        .vote_label (vote_label),
        .vote_valid (vote_valid)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int unsigned px [1024];
    int unsigned py [1024];
    int unsigned pl [1024];
    int          mem_delay = 0;
    bit          seen_req  = 0;

    logic [DIST_W-1:0] acc;
    assign dp_dist = acc;

    function automatic logic [DIST_W-1:0] sqd(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        longint d;
        d = longint'(a) - longint'(b);
        return DIST_W'(d * d);
    endfunction

    always @(posedge clk) begin
        if (rst || dp_rst_acc) acc <= '0;
        else if (dp_en) acc <= acc + sqd(dp_a, dp_b);
    end

    initial begin : mem_resp
        int w;
        bit pend;
        logic [IDX_W-1:0] hold;
        mem_ack = 0; mem_x = '0; mem_y = '0; mem_label = '0;
        w = 0; pend = 0; hold = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                seen_req = 1;
                if (pend) chk("addr hold", 64'(mem_addr), 64'(hold));
                else hold = mem_addr;
                pend = 1;
                if (w >= mem_delay) begin
                    mem_ack   = 1;
                    mem_x     = DATA_W'(px[mem_addr]);
                    mem_y     = DATA_W'(py[mem_addr]);
                    mem_label = LABEL_W'(pl[mem_addr]);
                    w = 0;
                    pend = 0;
                end else begin
                    mem_ack = 0;
                    w++;
                end
            end else begin
                mem_ack = 0;
                w = 0;
                pend = 0;
            end
        end
    end

    bit          e_vld  [K];
    longint      e_dist [K];
    int          e_idx  [K];
    int unsigned e_lbl  [K];
`ifdef KNN_CTRL_VOTE_EN
    int unsigned e_vlbl;
    bit          e_vvalid;
`endif

    // Stable top-K selection: smallest distance first, lower index on ties
    task automatic ref_topk(input int n, input int tx, input int ty);
        longint d [1024];
        bit     used [1024];
        int     best;
        for (int i = 0; i < n; i++) begin
            d[i] = (longint'(tx) - longint'(px[i])) ** 2
                 + (longint'(ty) - longint'(py[i])) ** 2;
            used[i] = 0;
        end
        for (int s = 0; s < K; s++) begin
            best = -1;
            for (int i = 0; i < n; i++) begin
                if (!used[i] && (best < 0 || d[i] < d[best])) best = i;
            end
            e_vld[s] = (best >= 0);
            if (best >= 0) begin
                used[best] = 1;
                e_dist[s] = d[best];
                e_idx[s]  = best;
                e_lbl[s]  = pl[best];
            end
        end
`ifdef KNN_CTRL_VOTE_EN
        begin
            int bc, c;
            bc = 0; e_vlbl = 0; e_vvalid = e_vld[0];
            for (int s = 0; s < K; s++) begin
                c = 0;
                for (int t = 0; t < K; t++)
                    if (e_vld[s] && e_vld[t] && e_lbl[t] == e_lbl[s]) c++;
                if (c > bc) begin
                    bc = c;
                    e_vlbl = e_lbl[s];
                end
            end
        end
`endif
    endtask

    task automatic check_slots(input string tag);
        for (int s = 0; s < K; s++) begin
            rd_slot = SW'(s);
            #1;
            chk($sformatf("%s s%0d valid", tag, s), 64'(rd_valid), 64'(e_vld[s]));
            if (e_vld[s]) begin
                chk($sformatf("%s s%0d dist", tag, s), 64'(rd_dist), 64'(e_dist[s]));
                chk($sformatf("%s s%0d idx", tag, s), 64'(rd_index), 64'(e_idx[s]));
                chk($sformatf("%s s%0d lbl", tag, s), 64'(rd_label), 64'(e_lbl[s]));
            end
        end
    endtask

    task automatic run(input int n, input int tx, input int ty, input int dly,
                       input int poke_at, input string tag);
        int cyc, exp_cyc, budget, extra;
        bit pbusy;
        mem_delay = dly;
        seen_req  = 0;
        @(negedge clk);
        n_points = IDX_W'(n);
        test_x   = DATA_W'(tx);
        test_y   = DATA_W'(ty);
        start    = 1;
        @(negedge clk);
        start = 0;
        cyc   = 1;
        chk({tag, " busy rise"}, 64'(busy), 64'(1));
        exp_cyc = (n == 0) ? 2 : n * (5 + DP_LAT + dly) + 2;
`ifdef KNN_CTRL_VOTE_EN
        if (n > 0) exp_cyc += K;
`endif
        budget = exp_cyc + 40;
        pbusy  = busy;
        while (!done && cyc < budget) begin
            pbusy = busy;
            start = (cyc == poke_at);
            if (cyc == poke_at) begin
                n_points = IDX_W'(n + 3);
                test_x   = DATA_W'(tx + 7);
            end
            @(negedge clk);
            cyc++;
        end
        start = 0;
        chk({tag, " done"}, 64'(done), 64'(1));
        chk({tag, " cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " busy at done"}, 64'(busy), 64'(0));
        chk({tag, " busy before done"}, 64'(pbusy), 64'(1));
        ref_topk(n, tx, ty);
`ifdef KNN_CTRL_VOTE_EN
        chk({tag, " vote valid"}, 64'(vote_valid), 64'(e_vvalid));
        if (e_vvalid) chk({tag, " vote label"}, 64'(vote_label), 64'(e_vlbl));
`endif
        check_slots(tag);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk({tag, " single done"}, 64'(extra), 64'(0));
    endtask

    task automatic load_basic();
        px[0] = 3; py[0] = 4; pl[0] = 7;
        px[1] = 1; py[1] = 1; pl[1] = 2;
        px[2] = 0; py[2] = 2; pl[2] = 2;
        px[3] = 5; py[3] = 0; pl[3] = 9;
        px[4] = 1; py[4] = 0; pl[4] = 2;
    endtask

    initial begin
        int en, cyc, extra, n, rng, tx, ty, dly;
        rst = 1; start = 0; n_points = '0; test_x = '0; test_y = '0;
        rd_slot = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst ctl", 64'({busy, done, mem_req, dp_rst_acc, dp_en}), 64'(0));
        chk("rst addr", 64'(mem_addr), 64'(0));
        chk("rst dp_a", 64'(dp_a), 64'(0));
        chk("rst dp_b", 64'(dp_b), 64'(0));
        for (int s = 0; s < K; s++) begin
            rd_slot = SW'(s);
            #1;
            chk($sformatf("rst s%0d valid", s), 64'(rd_valid), 64'(0));
        end

        load_basic();
        run(5, 0, 0, 0, -1, "basic");
        rd_slot = SW'(3);
        #1;
        chk("basic tie keeps idx0", 64'(rd_index), 64'(0));
`ifdef KNN_CTRL_VOTE_EN
        chk("basic vote2", 64'(vote_label), 64'(2));
`endif

        run(0, 0, 0, 0, -1, "empty");
        chk("empty no req", 64'(seen_req), 64'(0));

        px[0] = 2; py[0] = 0; pl[0] = 5;
        px[1] = 1; py[1] = 0; pl[1] = 6;
        run(2, 0, 0, 0, -1, "two");

        load_basic();
        run(5, 0, 0, 3, -1, "backpressure");
        run(5, 0, 0, 0, 10, "poke");

        // Abort on the second accumulate of point 2
        @(negedge clk);
        n_points = IDX_W'(5); test_x = '0; test_y = '0; start = 1;
        @(negedge clk);
        start = 0; en = 0; cyc = 0;
        while (cyc < 200) begin
            if (dp_en) en++;
            if (en == 6) break;
            @(negedge clk);
            cyc++;
        end
        chk("abort reach", 64'(en), 64'(6));
        chk("abort acc1 y", 64'(dp_b), 64'(py[2]));
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort ctl", 64'({busy, done, mem_req, dp_rst_acc, dp_en}), 64'(0));
        chk("abort addr", 64'(mem_addr), 64'(0));
        chk("abort dp", 64'({dp_a, dp_b}), 64'(0));
        for (int s = 0; s < K; s++) begin
            rd_slot = SW'(s);
            #1;
            chk($sformatf("abort s%0d valid", s), 64'(rd_valid), 64'(0));
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("abort no done", 64'(extra), 64'(0));
        run(5, 0, 0, 0, -1, "fresh");

        for (int r = 0; r < 8; r++) begin
            n   = $urandom_range(1, 12);
            rng = ($urandom_range(0, 1) == 1) ? 30000 : 3;
            for (int i = 0; i < n; i++) begin
                px[i] = $urandom_range(0, rng);
                py[i] = $urandom_range(0, rng);
                pl[i] = $urandom_range(0, 3);
            end
            tx  = $urandom_range(0, rng);
            ty  = $urandom_range(0, rng);
            dly = $urandom_range(0, 2);
            run(n, tx, ty, dly, -1, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
